// File: rtl/instruction_encoder_loader_if.sv
// Request and instruction-memory bus of the encoder/loader.
// Valid/ready: a request transfers on a cycle where in_valid && in_ready; a memory write
// completes on a cycle where mem_we && mem_ready, and mem_we/mem_addr/mem_wdata hold until it does.
interface instruction_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              addr_load;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err_illegal;
  logic              addr_wrapped;
  logic [15:0]       words_written;

  modport master (
    output in_valid, op_sel, rd, rs1, rs2, imm, addr_load, base_addr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, err_illegal, addr_wrapped, words_written
  );

  modport slave (
    input  in_valid, op_sel, rd, rs1, rs2, imm, addr_load, base_addr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, err_illegal, addr_wrapped, words_written
  );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Encodes RV32I subset requests into machine words, buffers them in a first-word-fall-through
// FIFO and writes them to instruction memory at an auto-incrementing word address.
module instruction_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input logic clk,
  input logic rst,
  instruction_encoder_loader_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr;
  logic              err_q;
  logic              wrapped_q;
  logic [15:0]       written_q;

  logic        full;
  logic        empty;
  logic        accept;
  logic        illegal;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign illegal = (bus.op_sel == 3'd7);
  assign accept  = bus.in_valid && bus.in_ready;
  assign push    = accept && !illegal;
  assign pop     = bus.mem_we && bus.mem_ready;

  // Everything facing the outside is forced quiet while rst is high, so a reset
  // cycle can never complete a memory write of a word that is being discarded.
  assign bus.in_ready      = !full && !rst;
  assign bus.mem_we        = !empty && !rst;
  assign bus.mem_addr      = rst ? '0 : addr;
  assign bus.mem_wdata     = bus.mem_we ? fifo_mem[rd_ptr] : '0;
  assign bus.err_illegal   = err_q;
  assign bus.addr_wrapped  = wrapped_q;
  assign bus.words_written = written_q;

  always_comb begin
    enc_word = '0;
    case (bus.op_sel)
      3'd0: enc_word = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      3'd1: enc_word = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
      3'd2: enc_word = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
      3'd3: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
      3'd4: enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
      3'd5: enc_word = {bus.imm[31:12], bus.rd, 7'b0110111};
      3'd6: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, 7'b1101111};
      default: enc_word = '0;
    endcase
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A load wins over the increment; a write completing this cycle still used the old address.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      wrapped_q <= 1'b0;
      written_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && illegal;
      if (pop) begin
        written_q <= written_q + 16'd1;
      end
      if (bus.addr_load) begin
        addr <= bus.base_addr;
      end else if (pop) begin
        addr <= addr + 1'b1;
        if (&addr) begin
          wrapped_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Bench for instruction_encoder_loader: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model of the loader.
module tb_instruction_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instruction_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory-side inputs come either from the directed code or from the random process.
  logic          rand_en   = 1'b0;
  logic          rnd_ready = 1'b1;
  logic          rnd_load  = 1'b0;
  logic [AW-1:0] rnd_base  = '0;
  logic          man_ready = 1'b0;
  logic          man_load  = 1'b0;
  logic [AW-1:0] man_base  = '0;

  assign bus.mem_ready = rand_en ? rnd_ready : man_ready;
  assign bus.addr_load = rand_en ? rnd_load  : man_load;
  assign bus.base_addr = rand_en ? rnd_base  : man_base;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
    rnd_load  = ($urandom_range(0, 15) == 0);
    rnd_base  = AW'($urandom_range(0, 255));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction layout written as shifted fields.
  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd_v,
                                     input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                     input logic [31:0] imm_v);
    logic [31:0] d, s1, s2, r_type;
    d  = 32'(rd_v);
    s1 = 32'(rs1_v);
    s2 = 32'(rs2_v);
    r_type = (s2 << 20) | (s1 << 15) | (d << 7) | 32'h33;
    case (op)
      3'd0: return r_type;
      3'd1: return r_type | 32'h4000_0000;
      3'd2: return ((imm_v & 32'hFFF) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      3'd3: return (((imm_v >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                   | ((imm_v & 32'h1F) << 7) | 32'h23;
      3'd4: return ((imm_v & 32'hFFF) << 20) | (s1 << 15) | (d << 7) | 32'h13;
      3'd5: return (imm_v & 32'hFFFF_F000) | (d << 7) | 32'h37;
      3'd6: return (((imm_v >> 20) & 32'h1) << 31) | (((imm_v >> 1) & 32'h3FF) << 21)
                   | (((imm_v >> 11) & 32'h1) << 20) | (((imm_v >> 12) & 32'hFF) << 12)
                   | (d << 7) | 32'h6F;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: words pending in accept order, plus address/count/flag state.
  logic [31:0]   exp_q[$];
  logic [AW-1:0] m_addr    = '0;
  logic          m_wrapped = 1'b0;
  logic [15:0]   m_ww      = '0;
  logic          m_err     = 1'b0;
  logic          chk_en    = 1'b0;
  logic          m_acc;
  logic          m_pop;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_addr    = '0;
      m_wrapped = 1'b0;
      m_ww      = '0;
      m_err     = 1'b0;
      chk_en    = 1'b1;
    end else begin
      m_acc = bus.in_valid && (exp_q.size() < DEPTH);
      m_pop = (exp_q.size() > 0) && bus.mem_ready;
      m_err = m_acc && (bus.op_sel == 3'd7);
      if (m_pop) begin
        exp_q.delete(0);
        m_ww++;
        if (!bus.addr_load) begin
          if (m_addr == {AW{1'b1}}) m_wrapped = 1'b1;
          m_addr++;
        end
      end
      if (bus.addr_load) m_addr = bus.base_addr;
      if (m_acc && bus.op_sel != 3'd7)
        exp_q.push_back(enc(bus.op_sel, bus.rd, bus.rs1, bus.rs2, bus.imm));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(!rst && exp_q.size() < DEPTH));
      check("mem_we", 32'(bus.mem_we), 32'(!rst && exp_q.size() > 0));
      check("mem_addr", 32'(bus.mem_addr), rst ? 32'd0 : 32'(m_addr));
      if (!rst && exp_q.size() > 0) check("mem_wdata", bus.mem_wdata, exp_q[0]);
      check("err_illegal", 32'(bus.err_illegal), 32'(m_err));
      check("addr_wrapped", 32'(bus.addr_wrapped), 32'(m_wrapped));
      check("words_written", 32'(bus.words_written), 32'(m_ww));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [31:0] imm_v);
    logic r;
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_sel   = op;
    bus.rd       = rd_v;
    bus.rs1      = rs1_v;
    bus.rs2      = rs2_v;
    bus.imm      = imm_v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      step();
      if (r) begin
        done = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  seq_op  [6] = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [4:0]  seq_rd  [6] = '{5'd3, 5'd5, 5'd6, 5'd0, 5'd1, 5'd1};
  logic [4:0]  seq_rs1 [6] = '{5'd1, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
  logic [4:0]  seq_rs2 [6] = '{5'd2, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0};
  logic [31:0] seq_imm [6] = '{32'd0, 32'hFFF, 32'd8, 32'd12, 32'h1234_5000, 32'd8};
  logic [31:0] seq_lit [6] = '{32'h402081B3, 32'hFFF00293, 32'h00812303, 32'h00712623,
                               32'h123450B7, 32'h008000EF};
  logic [AW-1:0] wrap_lit [3] = '{8'hFE, 8'hFF, 8'h00};

  initial begin
    bus.in_valid = 1'b0;
    bus.op_sel   = '0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;
    do_reset();

    check("model_pin_add", enc(3'd0, 5'd3, 5'd1, 5'd2, 32'd0), 32'h002081B3);
    check("model_pin_sw", enc(3'd3, 5'd0, 5'd2, 5'd7, 32'd12), 32'h00712623);

    // Single ADD straight after reset.
    man_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check("add_we", 32'(bus.mem_we), 32'd1);
    check("add_addr", 32'(bus.mem_addr), 32'd0);
    check("add_wdata", bus.mem_wdata, 32'h002081B3);
    step();
    @(negedge clk);
    check("add_written", 32'(bus.words_written), 32'd1);
    step();

    // Every op format, written at consecutive addresses.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(seq_op[i], seq_rd[i], seq_rs1[i], seq_rs2[i], seq_imm[i]);
      @(negedge clk);
      check("seq_addr", 32'(bus.mem_addr), 32'(i));
      check("seq_wdata", bus.mem_wdata, seq_lit[i]);
      step();
    end

    // Backpressure: FIFO fills, the fifth request waits, head holds.
    man_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 5'd1, 5'd0, 5'd0, 32'(i + 1));
    bus.in_valid = 1'b1;
    bus.op_sel = 3'd4; bus.rd = 5'd1; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_head", bus.mem_wdata, 32'h00100093);
      check("full_addr", 32'(bus.mem_addr), 32'd6);
      step();
    end
    man_ready = 1'b1;
    send(3'd4, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    @(negedge clk);
    check("bp_written", 32'(bus.words_written), 32'd11);
    step();

    // Illegal op between two legal ones.
    do_reset();
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(3'd7, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF);
    @(negedge clk);
    check("illegal_pulse", 32'(bus.err_illegal), 32'd1);
    step();
    send(3'd1, 5'd3, 5'd1, 5'd2, 32'd0);
    drain();
    @(negedge clk);
    check("illegal_written", 32'(bus.words_written), 32'd2);
    step();

    // Address load near the top and wrap.
    do_reset();
    man_load = 1'b1;
    man_base = 8'hFE;
    step();
    man_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(3'd4, 5'(i + 1), 5'd0, 5'd0, 32'(i));
      @(negedge clk);
      check("wrap_addr", 32'(bus.mem_addr), 32'(wrap_lit[i]));
      step();
    end
    @(negedge clk);
    check("wrap_flag", 32'(bus.addr_wrapped), 32'd1);
    step();

    // Reset with words buffered and memory stalled.
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_we", 32'(bus.mem_we), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_we", 32'(bus.mem_we), 32'd0);
    check("post_rst_written", 32'(bus.words_written), 32'd0);
    check("post_rst_wrapped", 32'(bus.addr_wrapped), 32'd0);
    step();
    man_ready = 1'b1;
    send(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check("post_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("post_rst_wdata", bus.mem_wdata, 32'h002081B3);
    step();
    drain();

    // Randomized traffic with random stalls and address loads.
    do_reset();
    rand_en = 1'b1;
    for (int n = 0; n < 120; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      send(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), $urandom);
    end
    rand_en = 1'b0;
    man_ready = 1'b1;
    man_load = 1'b0;
    drain();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
- Converts field-level instruction requests (op select, rd, rs1, rs2, imm) into 32-bit RV32I machine words for the supported subset: ADD, SUB, LW, SW, ADDI, LUI, JAL.
- Buffers encoded words in a small FIFO and drains them into instruction memory at an auto-incrementing word address.
- Sits between the bench/boot controller and instruction memory, and produces the words that instruction_decoder consumes.

Parameters:
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, ≥2.
- ADDR_W, 8, instruction-memory word-address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid && in_ready.
- op_sel  input  3  0 ADD, 1 SUB, 2 LW, 3 SW, 4 ADDI, 5 LUI, 6 JAL, 7 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  32  immediate. I/S types use imm[11:0]; LUI uses imm[31:12]; JAL uses byte offset imm[20:1], with imm[0] ignored.
- addr_load  input  1  load base_addr into the write-address counter.
- base_addr  input  ADDR_W  new start word address.
- mem_we  output  1  write request to instruction memory.
- mem_ready  input  1  memory accepts the write when mem_we && mem_ready.
- mem_addr  output  ADDR_W  current word address.
- mem_wdata  output  32  encoded instruction word.
- err_illegal  output  1  one-cycle pulse, one cycle after an illegal op_sel is accepted.
- addr_wrapped  output  1  sticky; set when the address counter wraps.
- words_written  output  16  count of completed memory writes; wraps modulo 2^16.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. On a reset cycle:
  - FIFO is flushed.
  - mem_we, mem_addr, mem_wdata, err_illegal, addr_wrapped and words_written are all 0.
  - in_ready is 0 during the reset cycle and 1 on the following cycle.
  - Reset mid-operation discards buffered words with no memory write.
- Encoding (combinational from inputs, pushed on accept):
  - ADD = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}
  - SUB = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011}
  - LW = {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
  - SW = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
  - ADDI = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}
  - LUI = {imm[31:12], rd, 7'b0110111}
  - JAL = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}
  - Fields unused by an op are ignored.
- Accept: in_ready = !full.
  - A legal accept pushes the encoded word.
  - An illegal accept (op_sel = 7) is consumed, nothing is pushed, and err_illegal pulses on the next cycle.
- Drain: FIFO is first-word-fall-through.
  - mem_we = !empty; mem_wdata = FIFO head; mem_addr = counter.
  - Latency from accept to mem_we high is 1 cycle.
  - On mem_we && mem_ready: pop, increment the counter, increment words_written.
  - With mem_ready low, mem_we, mem_addr and mem_wdata hold stable.
- Simultaneous push and pop: allowed whenever not full; occupancy is unchanged. When full, in_ready = 0, so no push occurs even if a pop happens the same cycle.
- Address counter:
  - Increments modulo 2^ADDR_W.
  - The transition from all-ones to 0 sets addr_wrapped, which is cleared only by rst.
  - addr_load overrides increment. A write completing in the same cycle uses the pre-load address, and the counter becomes base_addr next cycle. Buffered words are kept.
- Ordering: memory writes occur in accept order, with no reordering or drop except illegal requests.

Test Plan:
- After reset, push ADD(rd=3, rs1=1, rs2=2) with mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3; then words_written=1.
- Push in sequence: SUB x3,x1,x2; ADDI x5,x0,imm=0xFFF; LW x6,8(x2); SW x7,12(x2); LUI x1,0x12345; JAL x1,+8 → writes in order at addresses 0..5 of 0x402081B3, 0xFFF00293, 0x00812303, 0x00712623, 0x123450B7, 0x008000EF.
- Hold mem_ready=0 and push 5 words (FIFO_DEPTH=4) → in_ready drops after the 4th accept and the 5th request waits; mem_wdata holds the first word; release mem_ready → all 5 written in order.
- Accept op_sel=7 between two legal ops → err_illegal pulses 1 cycle later; exactly 2 memory writes; words_written=2.
- addr_load with base_addr=0xFE, then 3 pushes → writes to 0xFE, 0xFF, 0x00; addr_wrapped=1 from the cycle after the 0xFF write.
- Assert rst with 3 words buffered and mem_ready=0 → no further mem_we; all outputs 0; a subsequent push writes to address 0.
